// File: rtl/ahb_manager.sv
// AHB-Lite manager, 64-bit data, one command at a time, pipelined address/data phases.
// Optional INCR bursts (NONSEQ/SEQ/BUSY) when AHB_MGR_BURST_EN is defined; otherwise SINGLE/NONSEQ/IDLE.

module ahb_mgr_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q, cnt_d;

  // Push and pop together while full lands the new word in the slot being freed.
  assign cnt_d  = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  assign head_o = mem_q[rp_q];
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= push_dat_i;
        wp_q        <= ~wp_q;
      end
      if (pop_i) rp_q <= ~rp_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

module ahb_manager (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_addr,
  input  logic [7:0]  cmd_beats,
  input  logic [1:0]  cmd_size,
  input  logic [63:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [63:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        done,
  output logic        err,
  output logic        hsel,
  output logic [9:0]  haddr,
  output logic [1:0]  htrans,
  output logic [1:0]  hsize,
  output logic        hwrite,
  output logic [2:0]  hburst,
  output logic [63:0] hwdata,
  input  logic [63:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

`ifdef AHB_MGR_BURST_EN
  localparam logic BurstEn = 1'b1;
`else
  localparam logic BurstEn = 1'b0;
`endif

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_LAST = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  beats_q, beats_d;
  logic [1:0]  size_q, size_d;
  logic        burst_q, burst_d;
  logic        started_q, started_d;
  logic        dp_vld_q, dp_vld_d;
  logic        dp_write_q, dp_write_d;
  logic [63:0] hwdata_q, hwdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        fifo_push, fifo_pop;
  logic [1:0]  fifo_cnt;
  logic [63:0] fifo_head;
  logic        rd_out;
  logic [2:0]  rd_need;
  logic        rd_space;
  logic        issue, accept;
  logic        dp_done, dp_err_early;

  ahb_mgr_fifo #(.W(64)) u_rd_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_dat_i (hrdata),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .cnt_o      (fifo_cnt)
  );

  assign rd_valid = (fifo_cnt != 2'd0);
  assign rd_data  = fifo_head;
  assign fifo_pop = rd_valid && rd_ready;

  // An outstanding read data phase reserves a FIFO slot before its data arrives.
  assign rd_out   = dp_vld_q && !dp_write_q;
  assign rd_need  = {1'b0, fifo_cnt} + {2'b00, rd_out} - {2'b00, fifo_pop};
  assign rd_space = (rd_need < 3'd2);

  assign issue        = (state_q == S_XFER) && (write_q ? wr_valid : rd_space);
  assign accept       = issue && hready;
  assign dp_done      = dp_vld_q && hready;
  assign dp_err_early = dp_vld_q && !hready && hresp;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    size_d     = size_q;
    burst_d    = burst_q;
    started_d  = started_q;
    dp_vld_d   = dp_vld_q;
    dp_write_d = dp_write_q;
    hwdata_d   = hwdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fifo_push  = 1'b0;
    cmd_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          write_d   = cmd_write;
          addr_d    = cmd_addr;
          beats_d   = cmd_beats;
          size_d    = cmd_size;
          burst_d   = BurstEn && (cmd_beats > 8'd1);
          started_d = 1'b0;
          dp_vld_d  = 1'b0;
          if (cmd_beats == 8'd0) done_d  = 1'b1;
          else                   state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (dp_err_early) begin
          state_d = S_ERR;
        end else if (dp_done && hresp) begin
          err_d    = 1'b1;
          dp_vld_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          if (dp_done) begin
            dp_vld_d  = 1'b0;
            fifo_push = !dp_write_q;
          end
          if (accept) begin
            dp_vld_d   = 1'b1;
            dp_write_d = write_q;
            addr_d     = addr_q + (10'd1 << size_q);
            beats_d    = beats_q - 8'd1;
            started_d  = 1'b1;
            if (write_q) hwdata_d = wr_data;
            if (beats_q == 8'd1) state_d = S_LAST;
          end
        end
      end

      S_LAST: begin
        if (dp_err_early) begin
          state_d = S_ERR;
        end else if (dp_done) begin
          dp_vld_d = 1'b0;
          state_d  = S_IDLE;
          if (hresp) begin
            err_d = 1'b1;
          end else begin
            done_d    = 1'b1;
            fifo_push = !dp_write_q;
          end
        end
      end

      S_ERR: begin
        // Second cycle of the error response: remaining beats are dropped.
        if (hready) begin
          err_d    = 1'b1;
          dp_vld_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    htrans = TransIdle;
    if (issue)                                           htrans = (burst_q && started_q) ? TransSeq : TransNonseq;
    else if ((state_q == S_XFER) && burst_q && started_q) htrans = TransBusy;
  end

  assign hsel      = ((state_q == S_XFER) && (started_q || issue)) ||
                     (state_q == S_LAST) || (state_q == S_ERR);
  assign haddr     = addr_q;
  assign hsize     = size_q;
  assign hwrite    = write_q;
  assign hburst    = ((state_q != S_IDLE) && burst_q) ? 3'b001 : 3'b000;
  assign hwdata    = hwdata_q;
  assign wr_ready  = accept && write_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      addr_q     <= 10'd0;
      beats_q    <= 8'd0;
      size_q     <= 2'd0;
      burst_q    <= 1'b0;
      started_q  <= 1'b0;
      dp_vld_q   <= 1'b0;
      dp_write_q <= 1'b0;
      hwdata_q   <= 64'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      started_q  <= started_d;
      dp_vld_q   <= dp_vld_d;
      dp_write_q <= dp_write_d;
      hwdata_q   <= hwdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule
